// File: rtl/mult_sched.sv
// ---------------------------------------------------------------------------
// mult_sched
//
// Round-robin scheduler that shares one pipelined Q15 multiplier between NREQ
// requesters. Each cycle at most one requester is granted. The lowest asserted
// index at or after the round-robin pointer wins. The operand pair of the
// granted requester passes through three stages:
//   stage 1 : operands and requester id captured at the handshake edge
//   stage 2 : full 2*DSZ-bit signed product
//   stage 3 : round-half-up to DSZ+1 bits, saturate to DSZ bits (outputs)
// A response appears exactly three cycles after the handshake. Throughput is
// one result per cycle, and responses are never back-pressured.
//
// Optional feature:
//   MULT_SCHED_SAT_FLAG_EN  when defined, rsp_sat flags results that were
//                           clipped by saturation. When undefined, rsp_sat is
//                           tied to 0 and no flag register is built.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   DSZ   operand / result word size
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   reset      asynchronous, active-high reset
//   req_valid  [NREQ]      per-requester operand-pair valid
//   req_ready  [NREQ]      one-hot grant (combinational)
//   req_a      [NREQ*DSZ]  operand A, requester k in bits [k*DSZ +: DSZ]
//   req_b      [NREQ*DSZ]  operand B, same packing
//   rsp_valid              one-cycle pulse per accepted request
//   rsp_id     [clog2]     requester that owns the result
//   rsp_data   [DSZ]       rounded, saturated product
//   rsp_sat                result was clipped (feature-dependent)
// ---------------------------------------------------------------------------
module mult_sched #(
    parameter int NREQ = 4,
    parameter int DSZ  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*DSZ-1:0]     req_a,
    input  logic [NREQ*DSZ-1:0]     req_b,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [DSZ-1:0]          rsp_data,
    output logic                    rsp_sat
);

    localparam int IDW = $clog2(NREQ);

    // Unpacked views of the operand buses so the grant mux can index by id.
    logic [DSZ-1:0] a_arr [NREQ];
    logic [DSZ-1:0] b_arr [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign a_arr[k] = req_a[k*DSZ +: DSZ];
        assign b_arr[k] = req_b[k*DSZ +: DSZ];
    end

    // -----------------------------------------------------------------------
    // Round-robin arbiter
    // -----------------------------------------------------------------------
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  scan_idx;
    logic [NREQ-1:0] grant;
    logic            gnt_any;

    // NOTE: every variable gets a default before the search loop, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant    = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            // Walk the indices starting at the pointer, wrapping modulo NREQ.
            scan_idx = IDW'((int'(ptr) + i) % NREQ);
            if (!gnt_any && req_valid[scan_idx]) begin
                gnt_any         = 1'b1;
                gnt_idx         = scan_idx;
                grant[scan_idx] = 1'b1;
            end
        end
    end

    // The grant is masked while reset is high, so no handshake can complete.
    assign req_ready = reset ? '0 : grant;

    // -----------------------------------------------------------------------
    // Pipeline
    // -----------------------------------------------------------------------
    logic                  s1_valid;
    logic signed [DSZ-1:0] s1_a;
    logic signed [DSZ-1:0] s1_b;
    logic [IDW-1:0]        s1_id;

    logic                    s2_valid;
    logic signed [2*DSZ-1:0] s2_prod;
    logic [IDW-1:0]          s2_id;

    // Round-half-up: take product bits [2*DSZ-1:DSZ-2], add 1, drop the LSB.
    // The sum cannot overflow DSZ+2 bits, because the largest magnitude
    // product (-2^(DSZ-1))^2 needs only DSZ+1 bits after the shift.
    logic [DSZ+1:0] rnd_sum;
    logic [DSZ:0]   rnd;
    logic           clip;
    logic [DSZ-1:0] sat_data;

    always_comb begin
        rnd_sum = s2_prod[2*DSZ-1:DSZ-2] + (DSZ+2)'(1);
        rnd     = rnd_sum[DSZ+1:1];
        // The value fits in DSZ bits only if its top two bits agree.
        clip    = rnd[DSZ] ^ rnd[DSZ-1];
        if (clip) begin
            sat_data = rnd[DSZ] ? {1'b1, {(DSZ-1){1'b0}}}
                                : {1'b0, {(DSZ-1){1'b1}}};
        end else begin
            sat_data = rnd[DSZ-1:0];
        end
    end

    // These product bits fall below the rounding point and never matter.
    logic rnd_unused;
    assign rnd_unused = ^{s2_prod[DSZ-3:0], rnd_sum[0]};

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            if (gnt_any) begin
                ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            s1_valid  <= gnt_any;
            s2_valid  <= s1_valid;
            rsp_valid <= s2_valid;
            // Outputs hold their last values between responses.
            if (s2_valid) begin
                rsp_id   <= s2_id;
                rsp_data <= sat_data;
            end
        end
    end

    // NOTE: datapath registers have no reset. Their contents are qualified by
    // the valid bits, which are reset, so stale data is never presented.
    always_ff @(posedge clk) begin
        if (gnt_any) begin
            s1_a  <= a_arr[gnt_idx];
            s1_b  <= b_arr[gnt_idx];
            s1_id <= gnt_idx;
        end
        if (s1_valid) begin
            // Sign-extend before multiplying so the full product is kept.
            s2_prod <= (2*DSZ)'(s1_a) * (2*DSZ)'(s1_b);
            s2_id   <= s1_id;
        end
    end

`ifdef MULT_SCHED_SAT_FLAG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_sat <= 1'b0;
        end else if (s2_valid) begin
            rsp_sat <= clip;
        end
    end
`else
    assign rsp_sat = 1'b0;
`endif

endmodule

// File: tb/tb_mult_sched.sv
// ---------------------------------------------------------------------------
// tb_mult_sched
//
// Self-checking bench for mult_sched (NREQ=4, DSZ=16). A reference model
// follows the arbiter rule (first valid index at or after the pointer). It
// computes each expected result as floor((a*b + 2^14) / 2^15), clamped to the
// 16-bit signed range. Expected responses wait in a queue, each tagged with
// the cycle in which it must appear. Inputs change 1 time unit after the
// rising edge. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mult_sched;

    localparam int NREQ = 4;
    localparam int DSZ  = 16;
    localparam int IDW  = $clog2(NREQ);
    localparam longint MAXV = 32767;
    localparam longint MINV = -32768;

`ifdef MULT_SCHED_SAT_FLAG_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*DSZ-1:0]   req_a;
    logic [NREQ*DSZ-1:0]   req_b;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [DSZ-1:0]        rsp_data;
    logic                  rsp_sat;

    mult_sched #(.NREQ(NREQ), .DSZ(DSZ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_sat   (rsp_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int id;
        int data;
        bit sat;
    } rsp_t;

    rsp_t exp_q[$];
    int   grants_log[$];
    int   rspid_log[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int mptr     = 0;

    int last_id   = 0;
    int last_data = 0;
    bit last_sat  = 1'b0;

    int rsp_count     = 0;
    int rsp_seen_cyc  = 0;
    int rsp_seen_data = 0;
    int rsp_seen_sat  = 0;

    logic [DSZ-1:0] op_a [NREQ];
    logic [DSZ-1:0] op_b [NREQ];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Q15 product with round-half-up and saturation, in plain arithmetic.
    function automatic int q15_mul(input logic [DSZ-1:0] a, input logic [DSZ-1:0] b,
                                   output bit clipped);
        longint p;
        longint r;
        p = longint'($signed(a)) * longint'($signed(b));
        r = (p + (longint'(1) << (DSZ-2))) >>> (DSZ-1);
        clipped = 1'b0;
        if (r > MAXV) begin
            r = MAXV;
            clipped = 1'b1;
        end else if (r < MINV) begin
            r = MINV;
            clipped = 1'b1;
        end
        return int'(r);
    endfunction

    // One clock cycle: apply valid and operands, predict grant and responses,
    // then compare on the falling edge.
    task automatic do_cycle(input logic [NREQ-1:0] v);
        int             g;
        int             idx;
        int             dut_g;
        bit             clipped;
        int             d;
        rsp_t           e;
        logic [NREQ-1:0] exp_ready;
        @(posedge clk);
        #1;
        cyc++;
        req_valid = v;
        for (int k = 0; k < NREQ; k++) begin
            req_a[k*DSZ +: DSZ] = op_a[k];
            req_b[k*DSZ +: DSZ] = op_b[k];
        end
        g = -1;
        for (int i = 0; i < NREQ; i++) begin
            idx = (mptr + i) % NREQ;
            if (g < 0 && v[idx]) g = idx;
        end
        exp_ready = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            d = q15_mul(op_a[g], op_b[g], clipped);
            e.due  = cyc + 3;
            e.id   = g;
            e.data = d & 16'hFFFF;
            e.sat  = clipped & SAT_EN;
            exp_q.push_back(e);
            mptr = (g + 1) % NREQ;
        end
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        dut_g = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] === 1'b1 && dut_g < 0) dut_g = i;
        end
        if (dut_g >= 0) grants_log.push_back(dut_g);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_data", 32'(rsp_data), 32'(e.data));
            check("rsp_sat", 32'(rsp_sat), 32'(e.sat));
            last_id   = e.id;
            last_data = e.data;
            last_sat  = e.sat;
        end else begin
            check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            check("rsp_id_hold", 32'(rsp_id), 32'(last_id));
            check("rsp_data_hold", 32'(rsp_data), 32'(last_data));
            check("rsp_sat_hold", 32'(rsp_sat), 32'(last_sat));
        end
        if (rsp_valid === 1'b1) begin
            rsp_count++;
            rsp_seen_cyc  = cyc;
            rsp_seen_data = int'(rsp_data);
            rsp_seen_sat  = int'(rsp_sat);
            rspid_log.push_back(int'(rsp_id));
        end
    endtask

    // Assert reset for two cycles with every requester valid. The grant must
    // stay masked and all outputs must read 0.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = '1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rsp_id", 32'(rsp_id), 32'd0);
            check("rst_rsp_data", 32'(rsp_data), 32'd0);
            check("rst_rsp_sat", 32'(rsp_sat), 32'd0);
        end
        reset     = 1'b0;
        req_valid = '0;
        exp_q.delete();
        mptr      = 0;
        last_id   = 0;
        last_data = 0;
        last_sat  = 1'b0;
    endtask

    // Requester 0 alone for one cycle, then check the single response against
    // a hand-computed constant.
    task automatic directed(input string tag, input logic [DSZ-1:0] a, input logic [DSZ-1:0] b,
                            input logic [DSZ-1:0] exp_d, input bit exp_s);
        int hs_cyc;
        int cnt0;
        op_a[0] = a;
        op_b[0] = b;
        cnt0    = rsp_count;
        do_cycle(4'b0001);
        hs_cyc = cyc;
        for (int n = 0; n < 3; n++) do_cycle(4'b0000);
        check({tag, "_count"}, 32'(rsp_count - cnt0), 32'd1);
        check({tag, "_latency"}, 32'(rsp_seen_cyc - hs_cyc), 32'd3);
        check({tag, "_data"}, 32'(rsp_seen_data), 32'(exp_d));
        check({tag, "_sat"}, 32'(rsp_seen_sat), 32'(exp_s & SAT_EN));
    endtask

    task automatic randomize_ops();
        logic [DSZ-1:0] corner [4];
        corner[0] = 16'h8000;
        corner[1] = 16'h7FFF;
        corner[2] = 16'hFFFF;
        corner[3] = 16'h0000;
        for (int k = 0; k < NREQ; k++) begin
            op_a[k] = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : DSZ'($urandom);
            op_b[k] = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : DSZ'($urandom);
        end
    endtask

    initial begin
        int cnt0;
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        for (int k = 0; k < NREQ; k++) begin
            op_a[k] = '0;
            op_b[k] = '0;
        end

        do_reset();

        // Directed values: basic product, rounding up, rounding toward zero,
        // a negative result and positive saturation.
        directed("basic", 16'h4000, 16'h4000, 16'h2000, 1'b0);
        directed("round_pos", 16'h0001, 16'h4000, 16'h0001, 1'b0);
        directed("round_neg", 16'hFFFF, 16'h4000, 16'h0000, 1'b0);
        directed("negative", 16'h8000, 16'h4000, 16'hC000, 1'b0);
        directed("saturate", 16'h8000, 16'h8000, 16'h7FFF, 1'b1);

        // Fairness: all requesters valid for 12 cycles straight after reset.
        do_reset();
        randomize_ops();
        grants_log.delete();
        rspid_log.delete();
        for (int n = 0; n < 12; n++) do_cycle(4'b1111);
        for (int n = 0; n < 3; n++) do_cycle(4'b0000);
        check("fair_grants", 32'(grants_log.size()), 32'd12);
        check("fair_rsps", 32'(rspid_log.size()), 32'd12);
        for (int i = 0; i < 12 && i < grants_log.size() && i < rspid_log.size(); i++) begin
            check("fair_grant_order", 32'(grants_log[i]), 32'(i % 4));
            check("fair_rspid_order", 32'(rspid_log[i]), 32'(i % 4));
        end

        // Skip: move the pointer to 2, then only requesters 1 and 3 valid.
        do_reset();
        randomize_ops();
        do_cycle(4'b0010);
        grants_log.delete();
        for (int n = 0; n < 4; n++) do_cycle(4'b1010);
        do_cycle(4'b1111);
        for (int n = 0; n < 3; n++) do_cycle(4'b0000);
        check("skip_grants", 32'(grants_log.size()), 32'd5);
        if (grants_log.size() == 5) begin
            check("skip_g0", 32'(grants_log[0]), 32'd3);
            check("skip_g1", 32'(grants_log[1]), 32'd1);
            check("skip_g2", 32'(grants_log[2]), 32'd3);
            check("skip_g3", 32'(grants_log[3]), 32'd1);
            check("skip_ptr_end", 32'(grants_log[4]), 32'd2);
        end

        // One requester holding valid is granted every cycle.
        grants_log.delete();
        for (int n = 0; n < 8; n++) do_cycle(4'b0100);
        for (int n = 0; n < 3; n++) do_cycle(4'b0000);
        check("single_grants", 32'(grants_log.size()), 32'd8);
        foreach (grants_log[i]) check("single_grant_id", 32'(grants_log[i]), 32'd2);

        // Reset one cycle after two handshakes: nothing may emerge afterwards.
        randomize_ops();
        do_cycle(4'b0001);
        do_cycle(4'b0010);
        do_reset();
        cnt0 = rsp_count;
        for (int n = 0; n < 6; n++) do_cycle(4'b0000);
        check("midrst_no_rsp", 32'(rsp_count - cnt0), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            randomize_ops();
            do_cycle(NREQ'($urandom_range(0, 15)));
        end
        for (int n = 0; n < 4; n++) do_cycle(4'b0000);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 SHALL provide parameter NREQ, default 4, number of requesters sharing the multiplier (2..8).
REQ-002 SHALL provide parameter DSZ, default 16, operand and result word size.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port req_valid  input  NREQ  per-requester operand-pair valid.
REQ-006 SHALL provide port req_ready  output  NREQ  one-hot grant; handshake completes when valid and ready are both high.
REQ-007 SHALL provide port req_a  input  NREQ*DSZ  signed Q15 operand A, requester k in bits [k*DSZ +: DSZ].
REQ-008 SHALL provide port req_b  input  NREQ*DSZ  signed Q15 operand B, same packing.
REQ-009 SHALL provide port rsp_valid  output  1  result valid, one-cycle pulse per accepted request.
REQ-010 SHALL provide port rsp_id  output  clog2(NREQ)  index of the requester owning the result.
REQ-011 SHALL provide port rsp_data  output  DSZ  signed rounded, saturated product.
REQ-012 SHALL provide port rsp_sat  output  1  result was clipped (see REQ-027).

Function
REQ-013 SHALL grant at most one requester per cycle; req_ready is combinational from req_valid and the round-robin pointer.
REQ-014 SHALL grant the lowest index at or after the pointer, wrapping modulo NREQ, among asserted req_valid bits.
REQ-015 SHALL advance the pointer to (granted index + 1) mod NREQ on each handshake and hold it when no request is valid.
REQ-016 SHALL have no rsp back-pressure; every accepted request produces exactly one response, in acceptance order.
REQ-017 SHALL register the operands and id at the handshake edge (stage 1), form the full 2*DSZ signed product (stage 2), then round and saturate (stage 3).
REQ-018 SHALL present the response exactly 3 cycles after the handshake edge, with full throughput of one result per cycle.
REQ-019 SHALL round by taking product bits [2*DSZ-1:DSZ-2] (DSZ+2 bits), adding 1, and discarding the LSB, giving a DSZ+1-bit value (round-half-up).
REQ-020 SHALL saturate that DSZ+1-bit value to the range [-2^(DSZ-1), 2^(DSZ-1)-1].
REQ-021 SHALL carry rsp_id through the pipeline in lockstep with the data.
REQ-022 SHALL, when a single requester holds valid continuously, grant it every cycle.
REQ-023 SHALL, when all NREQ requesters hold valid, grant each exactly once in every NREQ consecutive cycles.
REQ-024 SHALL hold rsp_data, rsp_id and rsp_sat stable at their last values while rsp_valid is low.

Reset
REQ-025 SHALL, while reset is high, force req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_sat=0, the pointer to 0, and all pipeline valid bits to 0.
REQ-026 SHALL discard in-flight products on reset assertion mid-operation; no response is emitted for requests accepted before reset.

Configuration
REQ-027 SHALL, with macro MULT_SCHED_SAT_FLAG_EN defined, drive rsp_sat high with rsp_valid when REQ-020 clipped the value; without the macro, rsp_sat SHALL be constant 0 and no saturation-detect logic SHALL be built.

Verification
REQ-028 SHALL cover: req 0 only, a=0x4000, b=0x4000, one-cycle valid -> rsp_valid 3 cycles later, rsp_id=0, rsp_data=0x2000, rsp_sat=0.
REQ-029 SHALL cover rounding: a=0x0001, b=0x4000 -> 0x0001; a=0xFFFF, b=0x4000 -> 0x0000.
REQ-030 SHALL cover saturation: a=0x8000, b=0x8000 -> rsp_data=0x7FFF, rsp_sat=1 with the macro defined, rsp_sat=0 without.
REQ-031 SHALL cover fairness: all 4 requesters valid for 12 cycles after reset -> grant order 0,1,2,3 repeated 3 times, with rsp_id in the same order.
REQ-032 SHALL cover skip: only requesters 1 and 3 valid, pointer at 2 -> grants 3,1,3,1; pointer ends at 2.
REQ-033 SHALL cover reset mid-stream: reset asserted 1 cycle after 2 handshakes -> no rsp_valid pulse afterwards, and all outputs 0.
